// File: rtl/mux_pipeline.sv
// N-way registered datapath multiplexer with valid/ready on both sides.
// A 2-entry skid buffer keeps full throughput; out-of-range selects are flagged and counted.
module mux_pipeline #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              err_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    entry_t           head_q, head_d, tail_q, tail_d, new_entry;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             ready_q, valid_q;
    logic             push, pop;

    assign push = in_valid & ready_q;
    assign pop  = valid_q & out_ready;

    // Channel select; out-of-range selects store zero data with the error flag set.
    always_comb begin
        new_entry      = '0;
        new_entry.sel  = in_sel;
        new_entry.err  = (32'(in_sel) >= N_IN);
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                new_entry.data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy FSM and buffer steering.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    tail_d  = new_entry;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (push && new_entry.err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // Handshake flags are registered alongside the state they decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            err_cnt_q <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            err_cnt_q <= err_cnt_d;
            ready_q   <= (state_d != FULL);
            valid_q   <= (state_d != EMPTY);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = head_q.data;
    assign out_sel   = head_q.sel;
    assign out_err   = head_q.err;
    assign err_cnt   = err_cnt_q;

endmodule
